// File: rtl/inst_fetcher.sv
// Instruction fetcher: keeps at most one fetch outstanding, predicts JAL and
// backward conditional branches as taken, and buffers returned words in a
// small circular queue whose head is presented to the dispatcher.
module inst_fetcher #(
  parameter int unsigned IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic        wrong_commit,
  input  logic [31:0] redirect_pc,
  input  logic        issue_stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_jump
);

  localparam int unsigned PTR_W = $clog2(IQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IQ_DEPTH);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetchPc_q, fetchPc_d;
  logic               memReq_q, memReq_d;
  logic [31:0]        memAddr_q, memAddr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [31:0]        iqInst_q [IQ_DEPTH];
  logic [31:0]        iqPc_q   [IQ_DEPTH];
  logic               iqJump_q [IQ_DEPTH];

  logic               pushEn;
  logic               popEn;
  logic [6:0]         opcode;
  logic [31:0]        jImm;
  logic [31:0]        bImm;
  logic               predJump;
  logic [31:0]        predNext;

  // A response landing during a plain wait is the only source of pushes;
  // a flush in the same cycle throws it away, and also suppresses the pop.
  assign pushEn = rdy && (state_q == S_WAIT) && mem_valid && !wrong_commit;
  assign popEn  = rdy && if_valid && !issue_stall && !wrong_commit;

  // Static prediction on the returned word: JAL always taken, conditional
  // branches taken only when the offset is negative (sign bit set).
  always_comb begin
    opcode   = mem_inst[6:0];
    jImm     = {{11{mem_inst[31]}}, mem_inst[31], mem_inst[19:12],
                mem_inst[20], mem_inst[30:21], 1'b0};
    bImm     = {{19{mem_inst[31]}}, mem_inst[31], mem_inst[7],
                mem_inst[30:25], mem_inst[11:8], 1'b0};
    predJump = 1'b0;
    predNext = memAddr_q + 32'd4;
    if (opcode == OP_JAL) begin
      predJump = 1'b1;
      predNext = memAddr_q + jImm;
    end else if ((opcode == OP_BRANCH) && mem_inst[31]) begin
      predJump = 1'b1;
      predNext = memAddr_q + bImm;
    end
  end

  // Next-state logic for the fetch FSM, queue pointers and fetch PC; a flush
  // is applied last so it wins over any same-cycle push or pop.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    memReq_d  = memReq_q;
    memAddr_d = memAddr_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if (!wrong_commit && (count_q < DEPTH_CNT)) begin
            state_d   = S_WAIT;
            memReq_d  = 1'b1;
            memAddr_d = fetchPc_q;
          end
        end
        S_WAIT: begin
          if (mem_valid) begin
            state_d  = S_IDLE;
            memReq_d = 1'b0;
            if (!wrong_commit) begin
              fetchPc_d = predNext;
            end
          end else if (wrong_commit) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_valid) begin
            state_d  = S_IDLE;
            memReq_d = 1'b0;
          end
        end
        default: begin
          state_d  = S_IDLE;
          memReq_d = 1'b0;
        end
      endcase
      if (pushEn) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (popEn) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
      if (wrong_commit) begin
        head_d    = '0;
        tail_d    = '0;
        count_d   = '0;
        fetchPc_d = redirect_pc;
      end
    end
  end

  // Control registers with synchronous active-low reset that ignores rdy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      fetchPc_q <= RESET_PC;
      memReq_q  <= 1'b0;
      memAddr_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      memReq_q  <= memReq_d;
      memAddr_q <= memAddr_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (rst && pushEn) begin
      iqInst_q[tail_q] <= mem_inst;
      iqPc_q[tail_q]   <= memAddr_q;
      iqJump_q[tail_q] <= predJump;
    end
  end

  assign mem_req  = memReq_q;
  assign mem_addr = memAddr_q;

  assign if_valid = (count_q != '0);
  assign if_inst  = if_valid ? iqInst_q[head_q] : 32'h0;
  assign if_pc    = if_valid ? iqPc_q[head_q]   : 32'h0;
  assign if_jump  = if_valid ? iqJump_q[head_q] : 1'b0;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: a queue-based reference model is
// compared every cycle, plus directed sequences and a prediction table.
module tb_inst_fetcher;

  localparam int          D   = 8;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_inst;
  logic        wrong_commit;
  logic [31:0] redirect_pc;
  logic        issue_stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_jump;

  always #5 clk = ~clk;

  inst_fetcher #(.IQ_DEPTH(D), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_valid    (mem_valid),
    .mem_inst     (mem_inst),
    .wrong_commit (wrong_commit),
    .redirect_pc  (redirect_pc),
    .issue_stall  (issue_stall),
    .if_valid     (if_valid),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .if_jump      (if_jump)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jump;
  } entry_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        expJump;
    logic [31:0] expNext;
  } vec_t;

  entry_t      mq[$];
  logic [31:0] mFetchPc;
  logic [31:0] mAddr;
  logic        mOut;
  logic        mDrop;
  int          waitCnt;
  int          curLat;

  int          fixLat;
  bit          randLat;
  bit          randMem;
  logic        forceValid;
  logic [31:0] forceWord;
  logic [31:0] memOver [logic [31:0]];
  logic [31:0] progWords [6] = '{32'h00000013, 32'hFE000EE3, 32'h0080006F,
                                 32'h00000463, 32'h00008067, 32'hFFDFF06F};

  int checks   = 0;
  int failures = 0;

  vec_t vecs [6];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] idx;
    if (randMem) begin
      idx = ((a >> 2) ^ (a >> 5)) % 32'd6;
      return progWords[int'(idx)];
    end
    if (memOver.exists(a)) return memOver[a];
    return 32'h00000013;
  endfunction

  // Prediction rule computed arithmetically from the instruction fields.
  function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                  output logic jump, output logic [31:0] nxt);
    int off;
    jump = 1'b0;
    off  = 4;
    if (inst[6:0] == 7'b1101111) begin
      jump = 1'b1;
      off  = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
             - (inst[31] ? (1 << 20) : 0);
    end else if (inst[6:0] == 7'b1100011 && inst[31]) begin
      jump = 1'b1;
      off  = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048 - 4096;
    end
    nxt = pc + 32'(off);
  endfunction

  // Reference model update, using the inputs that were present at the edge.
  task automatic updateModel();
    int          sizePre;
    logic        pj;
    logic [31:0] pn;
    entry_t      e;
    if (!rst) begin
      mq.delete();
      mFetchPc = RPC;
      mAddr    = 32'h0;
      mOut     = 1'b0;
      mDrop    = 1'b0;
      waitCnt  = 0;
    end else if (rdy) begin
      sizePre = mq.size();
      if (sizePre > 0 && !issue_stall && !wrong_commit) void'(mq.pop_front());
      if (mOut) begin
        if (mem_valid) begin
          mOut = 1'b0;
          if (!mDrop && !wrong_commit) begin
            predict(mem_inst, mAddr, pj, pn);
            e.inst = mem_inst;
            e.pc   = mAddr;
            e.jump = pj;
            mq.push_back(e);
            mFetchPc = pn;
          end
        end else begin
          waitCnt++;
          if (wrong_commit) mDrop = 1'b1;
        end
      end else if (!wrong_commit && sizePre < D) begin
        mOut    = 1'b1;
        mAddr   = mFetchPc;
        mDrop   = 1'b0;
        waitCnt = 0;
        curLat  = randLat ? int'($urandom_range(0, 3)) : fixLat;
      end
      if (wrong_commit) begin
        mq.delete();
        mFetchPc = redirect_pc;
      end
    end
  endtask

  task automatic checkOutput();
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ej;
    ev = (mq.size() != 0);
    ei = 32'h0;
    ep = 32'h0;
    ej = 1'b0;
    if (ev) begin
      ei = mq[0].inst;
      ep = mq[0].pc;
      ej = mq[0].jump;
    end
    checkVal("if_valid", 32'(if_valid), 32'(ev));
    checkVal("if_inst", if_inst, ei);
    checkVal("if_pc", if_pc, ep);
    checkVal("if_jump", 32'(if_jump), 32'(ej));
    checkVal("mem_req", 32'(mem_req), 32'(mOut));
    checkVal("mem_addr", mem_addr, mAddr);
  endtask

  // One clock cycle: memory responder drives, model steps, outputs compared.
  task automatic applyStimulus();
    logic mv;
    mv = forceValid || (mOut && rdy && rst && (waitCnt >= curLat));
    mem_valid = mv;
    mem_inst  = forceValid ? forceWord : (mv ? memWord(mAddr) : $urandom());
    @(posedge clk);
    updateModel();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b0;
    rdy = 1'b0;
    applyStimulus();
    rdy = 1'b1;
    applyStimulus();
    rst = 1'b1;
  endtask

  task automatic waitReq(input string name, input logic [31:0] exp);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      applyStimulus();
      n++;
    end
    checkVal({name, "_req"}, 32'(mem_req), 32'd1);
    checkVal({name, "_addr"}, mem_addr, exp);
  endtask

  task automatic waitIfValid(input string name);
    int n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      applyStimulus();
      n++;
    end
    checkVal({name, "_valid"}, 32'(if_valid), 32'd1);
  endtask

  initial begin
    vecs[0] = '{32'h00000100, 32'hFE000EE3, 1'b1, 32'h000000FC};
    vecs[1] = '{32'h00000200, 32'h0080006F, 1'b1, 32'h00000208};
    vecs[2] = '{32'h00000300, 32'h00000463, 1'b0, 32'h00000304};
    vecs[3] = '{32'h00000040, 32'h00008067, 1'b0, 32'h00000044};
    vecs[4] = '{32'hFFFFFFFC, 32'h00000013, 1'b0, 32'h00000000};
    vecs[5] = '{32'h00000010, 32'hFFDFF06F, 1'b1, 32'h0000000C};

    rst = 1'b0; rdy = 1'b0; issue_stall = 1'b0; wrong_commit = 1'b0;
    redirect_pc = 32'h0; mem_valid = 1'b0; mem_inst = 32'h0;
    forceValid = 1'b0; forceWord = 32'h0;
    fixLat = 2; randLat = 1'b0; randMem = 1'b0;
    mq.delete(); mFetchPc = RPC; mAddr = 32'h0; mOut = 1'b0; mDrop = 1'b0;
    waitCnt = 0; curLat = 2;

    // Reset state, with rdy low during the first reset cycle.
    applyStimulus();
    checkVal("rst_mem_req", 32'(mem_req), 32'd0);
    checkVal("rst_mem_addr", mem_addr, 32'h0);
    checkVal("rst_if_valid", 32'(if_valid), 32'd0);
    rdy = 1'b1;
    applyStimulus();
    rst = 1'b1;

    // Basic fetch stream with two-cycle memory latency.
    applyStimulus();
    checkVal("first_req", 32'(mem_req), 32'd1);
    checkVal("first_addr", mem_addr, 32'h0);
    applyStimulus();
    applyStimulus();
    checkVal("no_bypass", 32'(if_valid), 32'd0);
    applyStimulus();
    checkVal("first_valid", 32'(if_valid), 32'd1);
    checkVal("first_pc", if_pc, 32'h0);
    checkVal("first_jump", 32'(if_jump), 32'd0);
    checkVal("req_gap", 32'(mem_req), 32'd0);
    applyStimulus();
    checkVal("second_addr", mem_addr, 32'h4);
    repeat (4) applyStimulus();
    checkVal("third_req", 32'(mem_req), 32'd1);
    checkVal("third_addr", mem_addr, 32'h8);

    // Stalled dispatcher fills the queue, then drains one per cycle.
    doReset();
    issue_stall = 1'b1;
    repeat (20) applyStimulus();
    checkVal("stall_mid_pc", if_pc, 32'h0);
    repeat (20) applyStimulus();
    checkVal("full_valid", 32'(if_valid), 32'd1);
    checkVal("full_pc", if_pc, 32'h0);
    checkVal("full_no_req", 32'(mem_req), 32'd0);
    issue_stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkVal("drain_valid", 32'(if_valid), 32'd1);
      checkVal("drain_pc", if_pc, 32'(i * 4));
      applyStimulus();
    end

    // Prediction table: redirect to the vector PC, check entry and next fetch.
    for (int v = 0; v < 6; v++) begin
      doReset();
      issue_stall  = 1'b1;
      memOver[vecs[v].pc] = vecs[v].inst;
      wrong_commit = 1'b1;
      redirect_pc  = vecs[v].pc;
      applyStimulus();
      wrong_commit = 1'b0;
      waitIfValid("vec");
      checkVal("vec_pc", if_pc, vecs[v].pc);
      checkVal("vec_inst", if_inst, vecs[v].inst);
      checkVal("vec_jump", 32'(if_jump), 32'(vecs[v].expJump));
      waitReq("vec_next", vecs[v].expNext);
    end

    // Reset in the middle of a request; a stale response afterwards is ignored.
    doReset();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    rst = 1'b1;
    forceValid = 1'b1;
    forceWord  = 32'h0080006F;
    applyStimulus();
    forceValid = 1'b0;
    checkVal("stale_req", 32'(mem_req), 32'd1);
    checkVal("stale_addr", mem_addr, 32'h0);
    applyStimulus();
    checkVal("stale_dropped", 32'(if_valid), 32'd0);

    // Flush while waiting: the late response is discarded.
    doReset();
    issue_stall = 1'b1;
    fixLat = 4;
    applyStimulus();
    applyStimulus();
    wrong_commit = 1'b1;
    redirect_pc  = 32'h400;
    applyStimulus();
    wrong_commit = 1'b0;
    checkVal("drain_req", 32'(mem_req), 32'd1);
    checkVal("drain_old_addr", mem_addr, 32'h0);
    applyStimulus();
    applyStimulus();
    checkVal("drain_hold_addr", mem_addr, 32'h0);
    checkVal("drain_empty", 32'(if_valid), 32'd0);
    applyStimulus();
    checkVal("drain_done_empty", 32'(if_valid), 32'd0);
    checkVal("drain_done_req", 32'(mem_req), 32'd0);
    waitReq("redirect400", 32'h400);
    waitIfValid("redirect400");
    checkVal("redirect400_pc", if_pc, 32'h400);

    // Flush coinciding with a response and a pop while three entries are held.
    doReset();
    issue_stall = 1'b1;
    fixLat = 2;
    for (int n = 0; n < 60; n++) begin
      if (mq.size() == 3 && mOut && waitCnt >= curLat) break;
      applyStimulus();
    end
    checkVal("c3_valid", 32'(if_valid), 32'd1);
    checkVal("c3_req", 32'(mem_req), 32'd1);
    issue_stall  = 1'b0;
    wrong_commit = 1'b1;
    redirect_pc  = 32'h800;
    applyStimulus();
    wrong_commit = 1'b0;
    issue_stall  = 1'b1;
    checkVal("c3_flushed", 32'(if_valid), 32'd0);
    checkVal("c3_no_req", 32'(mem_req), 32'd0);
    waitReq("redirect800", 32'h800);

    // rdy low freezes a queue of four, then popping resumes in order.
    doReset();
    issue_stall = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (mq.size() == 4) break;
      applyStimulus();
    end
    rdy = 1'b0;
    issue_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkVal("frozen_valid", 32'(if_valid), 32'd1);
      checkVal("frozen_pc", if_pc, 32'h0);
    end
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkVal("resume_pc", if_pc, 32'(i * 4));
      applyStimulus();
    end

    // Randomized traffic against the reference model.
    doReset();
    randLat = 1'b1;
    randMem = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      rdy          = ($urandom_range(0, 9) != 0);
      issue_stall  = ($urandom_range(0, 3) == 0);
      wrong_commit = ($urandom_range(0, 29) == 0);
      redirect_pc  = $urandom() & 32'hFFFF_FFFC;
      rst          = ($urandom_range(0, 199) != 0);
      applyStimulus();
    end
    rst = 1'b1;
    rdy = 1'b1;
    wrong_commit = 1'b0;
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
INST_FETCHER -- requirements
Module: inst_fetcher

Interface
REQ-001 Parameter IQ_DEPTH, 8, instruction-queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, 32'h0, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 rdy  input  1  global enable; 0 freezes all state.
REQ-006 mem_req  output  1  fetch request to instruction memory.
REQ-007 mem_addr  output  32  fetch address; stable while mem_req=1.
REQ-008 mem_valid  input  1  one-cycle pulse: mem_inst holds the word for mem_addr.
REQ-009 mem_inst  input  32  returned instruction word.
REQ-010 wrong_commit  input  1  mispredict flush from commit stage.
REQ-011 redirect_pc  input  32  correct PC; valid with wrong_commit.
REQ-012 issue_stall  input  1  dispatcher cannot accept this cycle.
REQ-013 if_valid  output  1  queue head valid.
REQ-014 if_inst  output  32  head instruction.
REQ-015 if_pc  output  32  head PC.
REQ-016 if_jump  output  1  head predicted taken.

Function
REQ-017 Outputs if_* SHALL be combinational from the queue head; if_inst/if_pc/if_jump SHALL be 0 when the queue is empty.
REQ-018 Pop SHALL occur when rdy=1, if_valid=1, issue_stall=0 and wrong_commit=0; head advances modulo IQ_DEPTH.
REQ-019 FSM states: IDLE, WAIT, DRAIN; at most one request outstanding.
REQ-020 IDLE: if count<IQ_DEPTH (pre-pop value), set mem_req=1, mem_addr=fetch_pc, enter WAIT next cycle; else remain IDLE with mem_req=0.
REQ-021 WAIT: mem_req=1 and mem_addr constant until the cycle mem_valid=1; mem_req SHALL be 0 from the following cycle.
REQ-022 WAIT and mem_valid=1: push {mem_inst, mem_addr, pred} at tail, update fetch_pc, return to IDLE; a push is visible on if_* the next cycle (no bypass).
REQ-023 Prediction: opcode 7'b1101111 (JAL) -> pred=1, next=pc+J-imm; opcode 7'b1100011 (branch) with imm[12]=1 -> pred=1, next=pc+B-imm; all others incl. JALR -> pred=0, next=pc+4; sums mod 2^32.
REQ-024 Simultaneous push and pop SHALL leave count unchanged; the push never overflows because requests issue only when count<IQ_DEPTH and no other push occurs while WAIT.
REQ-025 wrong_commit=1 (rdy=1) SHALL clear head, tail, count, and set fetch_pc=redirect_pc, overriding any same-cycle push/pop.
REQ-026 wrong_commit in IDLE -> IDLE; in WAIT with mem_valid=0 -> DRAIN; in WAIT with mem_valid=1 -> response discarded, IDLE; in DRAIN -> DRAIN, fetch_pc updated.
REQ-027 DRAIN: mem_req held 1 with old address until mem_valid; response discarded; then IDLE.
REQ-028 rdy=0 SHALL block state, pointer, count and fetch_pc updates; the memory side shares rdy and SHALL NOT pulse mem_valid while rdy=0.

Reset
REQ-029 rst=0 SHALL set state=IDLE, fetch_pc=RESET_PC, head=tail=count=0, mem_req=0, mem_addr=0, independent of rdy.
REQ-030 Reset asserted mid-request SHALL abandon it; a later mem_valid in IDLE SHALL be ignored.
REQ-031 First request SHALL issue in the first rdy=1 cycle after rst returns to 1.

Verification
REQ-032 Reset then mem_valid 2 cycles after each request, word 32'h00000013 -> mem_addr sequence 0,4,8; if_valid first high one cycle after first mem_valid, if_pc=0, if_jump=0.
REQ-033 issue_stall=1 for 40 cycles -> exactly 8 entries pushed, mem_req stays 0 in IDLE, if_pc remains 0; release -> 8 pops in 8 cycles with PCs 0..28.
REQ-034 Fetch at 0x100 returns 32'hFE000EE3 (beq, imm -4) -> entry if_jump=1, next mem_addr=0xFC; JAL 32'h0080006F at 0x200 -> next mem_addr=0x208, if_jump=1.
REQ-035 wrong_commit with redirect_pc=0x400 while WAIT, mem_valid 3 cycles later -> queue empty, response dropped, next mem_addr=0x400.
REQ-036 wrong_commit on same cycle as mem_valid and pop with count=3 -> count=0, if_valid=0 next cycle, next mem_addr=redirect_pc.
REQ-037 rdy=0 for 5 cycles with count=4 and issue_stall=0 -> count stays 4, if_pc unchanged, then resumes popping.
